// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file plus a sequencer for an external multi-cycle multiplier.
// MULT/MULTU hand held operands to the multiplier and wait in RUN for
// mult_end, with abort on flush or timeout. MTHI/MTLO write HI/LO directly.
// A one-cycle DONE state keeps mult_begin low between starts.
module mult_hilo_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mf_req,
  input  logic        flush,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  output logic        mult_sign,
  input  logic [63:0] mult_product,
  input  logic        mult_end,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        mult_err
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;

  // Last counter value before the abort fires; the counter is 6 bits wide.
  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand latch handed to the multiplier, frozen for the whole RUN.
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sign;
  } mreq_t;

  state_t     state, state_nxt;
  mreq_t      mreq;
  logic [5:0] cnt;

  // Decoded events. Ops are accepted only in IDLE and never on a flush cycle.
  logic accept, is_mult, start, wr_hi, wr_lo;
  logic run_end, run_tmo;

  assign accept  = (state == IDLE) & op_valid & ~flush;
  assign is_mult = (op_code == OP_MULT) | (op_code == OP_MULTU);
  assign start   = accept & is_mult;
  assign wr_hi   = accept & (op_code == OP_MTHI);
  assign wr_lo   = accept & (op_code == OP_MTLO);

  // Flush beats mult_end, and mult_end beats timeout.
  assign run_end = (state == RUN) & ~flush & mult_end;
  assign run_tmo = (state == RUN) & ~flush & ~mult_end & (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (flush | mult_end | (cnt == CNT_LAST)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and pipeline requests.
  always_comb begin
    busy       = (state != IDLE);
    mult_begin = (state == RUN);
    stall      = busy & (op_valid | mf_req);
  end

  // Operand latch, captured only when a multiply is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mreq <= '0;
    end else if (start) begin
      mreq.op1  <= src_a;
      mreq.op2  <= src_b;
      mreq.sign <= (op_code == OP_MULT);
    end
  end

  assign mult_op1  = mreq.op1;
  assign mult_op2  = mreq.op2;
  assign mult_sign = mreq.sign;

  // RUN cycle counter: cleared on entry, counts every RUN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             cnt <= '0;
    else if (start)          cnt <= '0;
    else if (state == RUN)   cnt <= cnt + 6'd1;
  end

  // HI/LO: direct moves in IDLE, product load on the mult_end edge in RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (run_end) begin
      hi <= mult_product[63:32];
      lo <= mult_product[31:0];
    end else begin
      if (wr_hi) hi <= src_a;
      if (wr_lo) lo <= src_a;
    end
  end

  // Timeout flag, high for the single DONE cycle that follows an abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mult_err <= 1'b0;
    else         mult_err <= run_tmo;
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: table of complete operations plus
// hand-written sequences for flush, timeout, stall and reset corners.
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        mf_req, flush;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic        mult_sign;
  logic [63:0] mult_product;
  logic        mult_end;
  logic [31:0] hi, lo;
  logic        busy, stall, mult_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.TIMEOUT(32)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .mf_req(mf_req), .flush(flush),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_sign(mult_sign), .mult_product(mult_product), .mult_end(mult_end),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .mult_err(mult_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present an op for one edge, then drop op_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    tick();
    op_valid = 1'b0; op_code = 3'b000;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          end_after;   // RUN cycle (1-based) on which mult_end is driven
    logic [63:0] prod;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_sign;
    int          exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0;
    mf_req = 1'b1; flush = 1'b0; mult_product = '0; mult_end = 1'b0;

    vecs[0] = '{"mult_neg",  3'b001, 32'hFFFFFFFE, 32'd3,        4, 64'hFFFFFFFF_FFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 5};
    vecs[1] = '{"multu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE, 32'h00000001, 1'b0, 3};
    vecs[2] = '{"mthi",      3'b011, 32'hA5A5A5A5, 32'h0,        0, 64'h0,                 32'hA5A5A5A5, 32'h00000001, 1'b0, 0};
    vecs[3] = '{"mtlo",      3'b100, 32'hCAFEF00D, 32'h0,        0, 64'h0,                 32'hA5A5A5A5, 32'hCAFEF00D, 1'b0, 0};
    vecs[4] = '{"nop000",    3'b000, 32'h11111111, 32'h0,        0, 64'h0,                 32'hA5A5A5A5, 32'hCAFEF00D, 1'b0, 0};
    vecs[5] = '{"mult_m14",  3'b001, 32'd7,        32'hFFFFFFFE, 1, 64'hFFFFFFFF_FFFFFFF2, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b1, 2};
    vecs[6] = '{"nop111",    3'b111, 32'h22222222, 32'h0,        0, 64'h0,                 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b1, 0};

    // Reset state, with mf_req high to show stall stays low.
    tick(); tick();
    chk("rst_hi", hi, 0);          chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);      chk("rst_begin", mult_begin, 0);
    chk("rst_op1", mult_op1, 0);   chk("rst_op2", mult_op2, 0);
    chk("rst_sign", mult_sign, 0); chk("rst_err", mult_err, 0);
    chk("rst_stall", stall, 0);
    mf_req = 1'b0;
    resetn = 1'b1;
    tick();

    // Table of complete operations.
    for (int i = 0; i < 7; i++) begin
      int nbusy, nrun, err_seen, done_begin;
      nbusy = 0; nrun = 0; err_seen = 0; done_begin = 0;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      for (int c = 0; c < 100; c++) begin
        if (!busy) break;
        nbusy++;
        if (mult_err) err_seen++;
        if (mult_begin) begin
          nrun++;
          chk({vecs[i].name, "_op1"}, mult_op1, vecs[i].a);
          chk({vecs[i].name, "_op2"}, mult_op2, vecs[i].b);
        end else begin
          done_begin = 1;
        end
        mult_end     = (nrun == vecs[i].end_after);
        mult_product = mult_end ? vecs[i].prod : 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
      end
      mult_end = 1'b0;
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      chk({vecs[i].name, "_sign"}, mult_sign, vecs[i].exp_sign);
      chk({vecs[i].name, "_busy"}, nbusy, vecs[i].exp_busy);
      chk({vecs[i].name, "_err"}, err_seen, 0);
      if (vecs[i].exp_busy > 0) chk({vecs[i].name, "_done_seen"}, done_begin, 1);
    end

    // MTHI then MFHI next cycle: never stalls, new value visible.
    op_valid = 1'b1; op_code = 3'b011; src_a = 32'h12345678;
    #1 chk("mthi_stall", stall, 0);
    tick();
    op_valid = 1'b0; mf_req = 1'b1;
    #1 chk("mfhi_stall", stall, 0);
    chk("mfhi_hi", hi, 32'h12345678);
    tick(); mf_req = 1'b0;

    // Flush and mult_end together on the 2nd RUN cycle: no write, no error.
    issue(3'b001, 32'd9, 32'd9);
    chk("fl_run1", mult_begin, 1);
    tick();
    flush = 1'b1; mult_end = 1'b1; mult_product = 64'h0123_4567_89AB_CDEF;
    tick();
    flush = 1'b0; mult_end = 1'b0;
    chk("fl_done_busy", busy, 1); chk("fl_done_begin", mult_begin, 0);
    chk("fl_err", mult_err, 0);
    chk("fl_hi", hi, 32'h12345678); chk("fl_lo", lo, 32'hFFFFFFF2);
    tick();
    chk("fl_idle", busy, 0);

    // Timeout: no mult_end for the whole RUN.
    begin
      int nrun = 0;
      issue(3'b010, 32'd4, 32'd5);
      for (int c = 0; c < 100; c++) begin
        if (!mult_begin) break;
        nrun++;
        chk("to_err_early", mult_err, 0);
        tick();
      end
      chk("to_runcyc", nrun, 32);
      chk("to_err", mult_err, 1); chk("to_done_busy", busy, 1);
      tick();
      chk("to_err_pulse", mult_err, 0); chk("to_idle", busy, 0);
      chk("to_hi", hi, 32'h12345678); chk("to_lo", lo, 32'hFFFFFFF2);
    end

    // mult_end in IDLE ignored; flush in IDLE suppresses ops.
    mult_end = 1'b1; mult_product = 64'hBBBB_BBBB_CCCC_CCCC;
    tick(); mult_end = 1'b0;
    chk("idle_end_hi", hi, 32'h12345678);
    flush = 1'b1;
    issue(3'b100, 32'h77777777, 32'h0);
    chk("fl_idle_lo", lo, 32'hFFFFFFF2);
    issue(3'b001, 32'd1, 32'd1);
    chk("fl_idle_mult", busy, 0);
    flush = 1'b0;

    // mf_req held through a multiply: stall through DONE, low in IDLE.
    mf_req = 1'b1;
    issue(3'b010, 32'd2, 32'd3);
    chk("st_run1", stall, 1); tick();
    mult_end = 1'b1; mult_product = 64'd6;
    chk("st_run2", stall, 1); tick();
    mult_end = 1'b0;
    chk("st_done", stall, 1); chk("st_done_busy", busy, 1); tick();
    chk("st_idle", stall, 0);
    chk("st_lo", lo, 32'd6); chk("st_hi", hi, 0);

    // Reset mid-RUN clears everything at once; next MULTU works normally.
    issue(3'b001, 32'd8, 32'd8);
    tick();
    resetn = 1'b0;
    #1;
    chk("rr_begin", mult_begin, 0); chk("rr_hi", hi, 0); chk("rr_lo", lo, 0);
    chk("rr_busy", busy, 0); chk("rr_stall", stall, 0); chk("rr_op1", mult_op1, 0);
    tick(); resetn = 1'b1; mf_req = 1'b0; tick();
    issue(3'b010, 32'd5, 32'd6);
    mult_end = 1'b1; mult_product = 64'd30;
    tick(); mult_end = 1'b0;
    chk("rr2_done", busy, 1); tick();
    chk("rr2_idle", busy, 0); chk("rr2_lo", lo, 32'd30); chk("rr2_err", mult_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: maximum RUN cycles to wait for mult_end before abort.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port op_valid, input, 1: HI/LO-class instruction present in EXE.
REQ-005 SHALL have port op_code, input, 3: 001 MULT, 010 MULTU, 011 MTHI, 100 MTLO; other codes are no-op.
REQ-006 SHALL have port src_a, input, 32: rs value, which is the MTHI/MTLO source.
REQ-007 SHALL have port src_b, input, 32: rt value.
REQ-008 SHALL have port mf_req, input, 1: MFHI/MFLO in EXE that needs HI/LO this cycle.
REQ-009 SHALL have port flush, input, 1: pipeline cancel.
REQ-010 SHALL have port mult_begin, output, 1: multiplier start level.
REQ-011 SHALL have ports mult_op1 and mult_op2, output, 32 each: held operands.
REQ-012 SHALL have port mult_sign, output, 1: 1 = signed.
REQ-013 SHALL have port mult_product, input, 64: multiplier result.
REQ-014 SHALL have port mult_end, input, 1: multiplier done.
REQ-015 SHALL have ports hi and lo, output, 32 each: architectural registers.
REQ-016 SHALL have port busy, output, 1: state != IDLE.
REQ-017 SHALL have port stall, output, 1: hold the pipeline.
REQ-018 SHALL have port mult_err, output, 1: one-cycle timeout pulse.

Function
REQ-019 FSM SHALL have three states, IDLE, RUN and DONE, and no others.
REQ-020 IDLE: when op_valid=1, flush=0 and op_code is MULT/MULTU, SHALL latch src_a into mult_op1 and src_b into mult_op2, set mult_sign (1 for MULT), and go to RUN.
REQ-021 IDLE: when op_valid=1, flush=0 and op_code is MTHI/MTLO, SHALL write src_a into hi or lo at that edge and stay in IDLE.
REQ-022 mult_begin SHALL be 1 exactly while in RUN, and mult_op1, mult_op2 and mult_sign SHALL be stable throughout RUN.
REQ-023 RUN: on mult_end=1 with flush=0, SHALL load {hi,lo}<=mult_product at that edge and go to DONE.
REQ-024 RUN: a 6-bit cycle counter SHALL clear on entry and increment each RUN cycle.
REQ-025 RUN: when the counter reaches TIMEOUT-1 with mult_end=0, SHALL go to DONE without writing HI/LO and pulse mult_err for one cycle.
REQ-026 RUN: flush=1 SHALL go to DONE without writing HI/LO.
REQ-027 Flush SHALL take priority over mult_end on the same edge.
REQ-028 mult_end SHALL take priority over timeout on the same edge.
REQ-029 DONE SHALL last exactly one cycle with mult_begin=0, then go to IDLE, so the multiplier always sees a low gap before its next start.
REQ-030 SHALL drive stall = busy & (op_valid | mf_req).
REQ-031 Ops presented while busy SHALL be ignored, because the pipeline re-presents them after stall drops.
REQ-032 hi and lo SHALL be registered outputs.
REQ-033 An MFHI/MFLO issued the cycle after DONE SHALL read the new product.
REQ-034 flush in IDLE SHALL suppress any accepted op that cycle.
REQ-035 mult_product SHALL be sampled only on the mult_end edge in RUN, and mult_end outside RUN SHALL be ignored.

Reset
REQ-036 resetn=0 SHALL immediately force state=IDLE, mult_begin=0, mult_op1=0, mult_op2=0, mult_sign=0, hi=0, lo=0, counter=0 and mult_err=0, with busy=0 and stall=0 following.
REQ-037 Reset during RUN SHALL abandon the operation with no HI/LO write, and the first post-reset MULT SHALL behave normally.

Verification
REQ-038 MULT src_a=0xFFFFFFFE, src_b=3, model asserts mult_end after 4 RUN cycles with product 0xFFFFFFFF_FFFFFFFA -> mult_sign=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA after DONE, busy high for 5 cycles.
REQ-039 MULTU 0xFFFFFFFF x 0xFFFFFFFF, product 0xFFFFFFFE_00000001 -> mult_sign=0, hi=0xFFFFFFFE, lo=0x00000001, mult_begin low during DONE.
REQ-040 MTHI 0x12345678 then MFHI in the next cycle -> hi=0x12345678, stall never asserted.
REQ-041 MULT, then flush on the 2nd RUN cycle, then mult_end on the same edge as flush -> HI/LO unchanged, DONE then IDLE, no mult_err.
REQ-042 MULT with mult_end never asserted, TIMEOUT=32 -> mult_err pulses after 32 RUN cycles, HI/LO unchanged, IDLE 2 cycles later.
REQ-043 mf_req held during RUN -> stall=1 through DONE and 0 in IDLE; resetn low mid-RUN -> mult_begin=0, hi=lo=0 in the same cycle.
